// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between pipeline_hazard_ctrl (slave) and the pipeline datapath (master).
// Carries hazard inputs, data-memory handshake, PC mux and pipeline-register controls.
interface pipeline_hazard_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] ID_rs1;
  logic [ADDR_W-1:0] ID_rs2;
  logic              ID_uses_rs1;
  logic              ID_uses_rs2;
  logic              EX_MemRead;
  logic [ADDR_W-1:0] EX_reg_write_addr;
  logic              MEM_Branch;
  logic              MEM_BranchFlip;
  logic              MEM_Jump;
  logic              MEM_zr;
  logic              MEM_MemRead;
  logic              MEM_MemWrite;
  logic [ADDR_W-1:0] MEM_branch_addr;
  logic [ADDR_W-1:0] MEM_jump_addr;
  logic              mem_ready;
  logic              mem_req;
  logic              pc_write;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] pc_target;
  logic              IFID_write;
  logic              IDEX_write;
  logic              EXMEM_write;
  logic              IFID_flush;
  logic              IDEX_flush;
  logic              EXMEM_flush;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_reg_write_addr,
    output MEM_Branch, MEM_BranchFlip, MEM_Jump, MEM_zr, MEM_MemRead, MEM_MemWrite,
    output MEM_branch_addr, MEM_jump_addr, mem_ready,
    input  mem_req, pc_write, pc_sel, pc_target, IFID_write, IDEX_write, EXMEM_write,
    input  IFID_flush, IDEX_flush, EXMEM_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_reg_write_addr,
    input  MEM_Branch, MEM_BranchFlip, MEM_Jump, MEM_zr, MEM_MemRead, MEM_MemWrite,
    input  MEM_branch_addr, MEM_jump_addr, mem_ready,
    output mem_req, pc_write, pc_sel, pc_target, IFID_write, IDEX_write, EXMEM_write,
    output IFID_flush, IDEX_flush, EXMEM_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline (priority: mem wait > redirect > load-use).
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W          = 32,
  parameter int LU_STALL_CYCLES = 1
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, REDIRECT} state_t;

  state_t            state_r, next_s;
  logic [2:0]        cnt_r, cnt_next_s;
  logic [1:0]        pc_sel_r, pc_sel_next_s;
  logic [ADDR_W-1:0] pc_target_r, pc_target_next_s;

  logic taken_s, mem_access_s, mem_busy_s, lu_s;
  logic pc_write_s, ifid_write_s, idex_write_s, exmem_write_s;
  logic ifid_flush_s, idex_flush_s, exmem_flush_s, mem_req_s;
  logic [1:0]        pc_sel_s;
  logic [ADDR_W-1:0] pc_target_s;

  assign taken_s      = bus.MEM_Jump | (bus.MEM_Branch & (bus.MEM_zr ^ bus.MEM_BranchFlip));
  assign mem_access_s = bus.MEM_MemRead | bus.MEM_MemWrite;
  assign mem_busy_s   = mem_access_s & ~bus.mem_ready;
  assign lu_s = bus.EX_MemRead & (bus.EX_reg_write_addr != {ADDR_W{1'b0}}) &
                ((bus.ID_uses_rs1 & (bus.ID_rs1 == bus.EX_reg_write_addr)) |
                 (bus.ID_uses_rs2 & (bus.ID_rs2 == bus.EX_reg_write_addr)));

  // State, bubble counter and latched redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      cnt_r       <= 3'd0;
      pc_sel_r    <= 2'd0;
      pc_target_r <= {ADDR_W{1'b0}};
    end else begin
      state_r     <= next_s;
      cnt_r       <= cnt_next_s;
      pc_sel_r    <= pc_sel_next_s;
      pc_target_r <= pc_target_next_s;
    end
  end

  // Next-state and pipeline control decode.
  always_comb begin
    next_s           = state_r;
    cnt_next_s       = cnt_r;
    pc_sel_next_s    = pc_sel_r;
    pc_target_next_s = pc_target_r;
    pc_write_s       = 1'b1;
    ifid_write_s     = 1'b1;
    idex_write_s     = 1'b1;
    exmem_write_s    = 1'b1;
    ifid_flush_s     = 1'b0;
    idex_flush_s     = 1'b0;
    exmem_flush_s    = 1'b0;
    mem_req_s        = mem_access_s;
    pc_sel_s         = 2'd0;
    pc_target_s      = {ADDR_W{1'b0}};
    if (rst) begin
      next_s           = RUN;
      cnt_next_s       = 3'd0;
      pc_sel_next_s    = 2'd0;
      pc_target_next_s = {ADDR_W{1'b0}};
      pc_write_s       = 1'b0;
      ifid_write_s     = 1'b0;
      idex_write_s     = 1'b0;
      exmem_write_s    = 1'b0;
      ifid_flush_s     = 1'b1;
      idex_flush_s     = 1'b1;
      exmem_flush_s    = 1'b1;
      mem_req_s        = 1'b0;
    end else begin
      case (state_r)
        REDIRECT: begin
          // Flushed stages may hold a stale memory access; it must not stall.
          pc_sel_s      = pc_sel_r;
          pc_target_s   = pc_target_r;
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          next_s        = RUN;
        end
        RUN, LU_STALL, MEM_WAIT: begin
          if (mem_busy_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            exmem_write_s = 1'b0;
            next_s        = MEM_WAIT;
          end else if (taken_s) begin
            pc_sel_next_s    = bus.MEM_Jump ? 2'd2 : 2'd1;
            pc_target_next_s = bus.MEM_Jump ? bus.MEM_jump_addr : bus.MEM_branch_addr;
            cnt_next_s       = 3'd0;
            next_s           = REDIRECT;
          end else if ((state_r == LU_STALL) || lu_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
            if (state_r == LU_STALL) begin
              if (cnt_r <= 3'd1) begin
                cnt_next_s = 3'd0;
                next_s     = RUN;
              end else begin
                cnt_next_s = cnt_r - 3'd1;
                next_s     = LU_STALL;
              end
            end else if (LU_STALL_CYCLES > 1) begin
              cnt_next_s = 3'(LU_STALL_CYCLES - 1);
              next_s     = LU_STALL;
            end else begin
              next_s = RUN;
            end
          end else begin
            next_s = RUN;
          end
        end
        default: begin
          next_s     = RUN;
          cnt_next_s = 3'd0;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_s;
  assign bus.pc_write    = pc_write_s;
  assign bus.pc_sel      = pc_sel_s;
  assign bus.pc_target   = pc_target_s;
  assign bus.IFID_write  = ifid_write_s;
  assign bus.IDEX_write  = idex_write_s;
  assign bus.EXMEM_write = exmem_write_s;
  assign bus.IFID_flush  = ifid_flush_s;
  assign bus.IDEX_flush  = idex_flush_s;
  assign bus.EXMEM_flush = exmem_flush_s;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_r, flush_cnt_r;

  // Saturating stall and redirect counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (!pc_write_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if ((state_r == REDIRECT) && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two controllers (LU_STALL_CYCLES=1 and 3) share stimulus; outputs checked per cycle.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  // {pc_write, IFID_w, IDEX_w, EXMEM_w, IFID_f, IDEX_f, EXMEM_f, mem_req, pc_sel}
  localparam logic [9:0] C_RST   = 10'b0_000_111_0_00;
  localparam logic [9:0] C_RUN   = 10'b1_111_000_0_00;
  localparam logic [9:0] C_RUNRQ = 10'b1_111_000_1_00;
  localparam logic [9:0] C_LU    = 10'b0_011_010_0_00;
  localparam logic [9:0] C_MW    = 10'b0_000_000_1_00;
  localparam logic [9:0] C_RDBR  = 10'b1_111_111_0_01;
  localparam logic [9:0] C_RDJRQ = 10'b1_111_111_1_10;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic [31:0] id_rs1, id_rs2, ex_rd, br_addr, j_addr;
  logic uses1, uses2, ex_mr, br, flip, jmp, zr, mr, mw, rdy;

  pipeline_hazard_ctrl_if #(.ADDR_W(32)) ifa ();
  pipeline_hazard_ctrl_if #(.ADDR_W(32)) ifb ();

  pipeline_hazard_ctrl #(.ADDR_W(32), .LU_STALL_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipeline_hazard_ctrl #(.ADDR_W(32), .LU_STALL_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  always_comb begin
    ifa.ID_rs1 = id_rs1;  ifb.ID_rs1 = id_rs1;
    ifa.ID_rs2 = id_rs2;  ifb.ID_rs2 = id_rs2;
    ifa.ID_uses_rs1 = uses1;  ifb.ID_uses_rs1 = uses1;
    ifa.ID_uses_rs2 = uses2;  ifb.ID_uses_rs2 = uses2;
    ifa.EX_MemRead = ex_mr;  ifb.EX_MemRead = ex_mr;
    ifa.EX_reg_write_addr = ex_rd;  ifb.EX_reg_write_addr = ex_rd;
    ifa.MEM_Branch = br;  ifb.MEM_Branch = br;
    ifa.MEM_BranchFlip = flip;  ifb.MEM_BranchFlip = flip;
    ifa.MEM_Jump = jmp;  ifb.MEM_Jump = jmp;
    ifa.MEM_zr = zr;  ifb.MEM_zr = zr;
    ifa.MEM_MemRead = mr;  ifb.MEM_MemRead = mr;
    ifa.MEM_MemWrite = mw;  ifb.MEM_MemWrite = mw;
    ifa.MEM_branch_addr = br_addr;  ifb.MEM_branch_addr = br_addr;
    ifa.MEM_jump_addr = j_addr;  ifb.MEM_jump_addr = j_addr;
    ifa.mem_ready = rdy;  ifb.mem_ready = rdy;
  end

  logic [9:0] ctl_a, ctl_b;
  assign ctl_a = {ifa.pc_write, ifa.IFID_write, ifa.IDEX_write, ifa.EXMEM_write,
                  ifa.IFID_flush, ifa.IDEX_flush, ifa.EXMEM_flush, ifa.mem_req, ifa.pc_sel};
  assign ctl_b = {ifb.pc_write, ifb.IFID_write, ifb.IDEX_write, ifb.EXMEM_write,
                  ifb.IFID_flush, ifb.IDEX_flush, ifb.EXMEM_flush, ifb.mem_req, ifb.pc_sel};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 32'd0; id_rs2 = 32'd0; ex_rd = 32'd0; br_addr = 32'd0; j_addr = 32'd0;
    uses1 = 1'b0; uses2 = 1'b0; ex_mr = 1'b0; br = 1'b0; flip = 1'b0; jmp = 1'b0;
    zr = 1'b0; mr = 1'b0; mw = 1'b0; rdy = 1'b0;
  endtask

  // Check both controllers mid-cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [9:0] ea, input logic [9:0] eb, input logic [31:0] et);
    @(negedge clk);
    chk({tag, "/ctl_a"}, 64'(ctl_a), 64'(ea));
    chk({tag, "/ctl_b"}, 64'(ctl_b), 64'(eb));
    chk({tag, "/tgt_a"}, 64'(ifa.pc_target), 64'(et));
    chk({tag, "/tgt_b"}, 64'(ifb.pc_target), 64'(et));
    @(posedge clk);
    #1;
  endtask

  task automatic perf(input string tag, input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] f);
    chk({tag, "/stall_a"}, 64'(ifa.stall_cnt), 64'(sa));
    chk({tag, "/stall_b"}, 64'(ifb.stall_cnt), 64'(sb));
    chk({tag, "/flush_a"}, 64'(ifa.flush_cnt), 64'(f));
    chk({tag, "/flush_b"}, 64'(ifb.flush_cnt), 64'(f));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step("rst0", C_RST, C_RST, 32'h0);
    step("rst1", C_RST, C_RST, 32'h0);
    perf("rst", 16'd0, 16'd0, 16'd0);
    rst = 1'b0;
    step("run", C_RUN, C_RUN, 32'h0);

    // Load-use via rs1
    ex_mr = 1'b1; ex_rd = 32'd5; id_rs1 = 32'd5; uses1 = 1'b1;
    step("lu1_0", C_LU, C_LU, 32'h0);
    idle();
    step("lu1_1", C_RUN, C_LU, 32'h0);
    step("lu1_2", C_RUN, C_LU, 32'h0);
    step("lu1_3", C_RUN, C_RUN, 32'h0);
    // Load-use via rs2
    ex_mr = 1'b1; ex_rd = 32'd5; id_rs2 = 32'd5; uses2 = 1'b1;
    step("lu2_0", C_LU, C_LU, 32'h0);
    idle();
    step("lu2_1", C_RUN, C_LU, 32'h0);
    step("lu2_2", C_RUN, C_LU, 32'h0);
    step("lu2_3", C_RUN, C_RUN, 32'h0);
    // Address match but operand unused, then r0 destination
    ex_mr = 1'b1; ex_rd = 32'd5; id_rs1 = 32'd5; id_rs2 = 32'd5;
    step("lu_nouse", C_RUN, C_RUN, 32'h0);
    ex_rd = 32'd0; id_rs1 = 32'd0; uses1 = 1'b1;
    step("lu_r0", C_RUN, C_RUN, 32'h0);
    idle();

    // Taken branch, then not-taken with BranchFlip
    br = 1'b1; zr = 1'b1; br_addr = 32'h40;
    step("br_0", C_RUN, C_RUN, 32'h0);
    idle();
    step("br_1", C_RDBR, C_RDBR, 32'h40);
    step("br_2", C_RUN, C_RUN, 32'h0);
    br = 1'b1; zr = 1'b1; flip = 1'b1; br_addr = 32'h40;
    step("nbr_0", C_RUN, C_RUN, 32'h0);
    idle();
    step("nbr_1", C_RUN, C_RUN, 32'h0);

    // Memory wait 3 cycles
    mr = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("mw_%0d", i), C_MW, C_MW, 32'h0);
    rdy = 1'b1;
    step("mw_rdy", C_RUNRQ, C_RUNRQ, 32'h0);
    idle();
    step("mw_done", C_RUN, C_RUN, 32'h0);

    // Jump during LU_STALL (dut_b), redirect ignores busy memory
    ex_mr = 1'b1; ex_rd = 32'd7; id_rs1 = 32'd7; uses1 = 1'b1;
    step("pri_lu", C_LU, C_LU, 32'h0);
    idle();
    jmp = 1'b1; j_addr = 32'h80;
    step("pri_jmp", C_RUN, C_RUN, 32'h0);
    idle();
    mr = 1'b1;
    step("pri_rd", C_RDJRQ, C_RDJRQ, 32'h80);
    idle();
    step("pri_after", C_RUN, C_RUN, 32'h0);
    perf("perf", PERF ? 16'd6 : 16'd0, PERF ? 16'd10 : 16'd0, PERF ? 16'd2 : 16'd0);

    // Reset in the middle of a stall
    ex_mr = 1'b1; ex_rd = 32'd3; id_rs2 = 32'd3; uses2 = 1'b1;
    step("rs_lu", C_LU, C_LU, 32'h0);
    idle();
    rst = 1'b1;
    step("rs_rst", C_RST, C_RST, 32'h0);
    perf("rs_perf", 16'd0, 16'd0, 16'd0);
    rst = 1'b0;
    step("rs_run", C_RUN, C_RUN, 32'h0);

`ifdef HAZARD_PERF_EN
    mr = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall_a", 64'(ifa.stall_cnt), 64'h0000_0000_0000_FFFF);
    chk("sat_stall_b", 64'(ifb.stall_cnt), 64'h0000_0000_0000_FFFF);
    idle();
    step("sat_end", C_RUN, C_RUN, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage 8-bit pipeline.
- Drives write-enable and flush controls into the IF/ID, ID/EX and EX/MEM registers, plus the PC mux.
- Resolves branch/jump in MEM, load-use hazards from EX, and multi-cycle data-memory handshakes.

Parameters:
- ADDR_W, 32, width of register-write addresses and PC targets.
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- ID_rs1, ID_rs2  input  ADDR_W  source register addresses of the instruction in ID.
- ID_uses_rs1, ID_uses_rs2  input  1  source operand actually read.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_reg_write_addr  input  ADDR_W  destination of the instruction in EX.
- MEM_Branch, MEM_BranchFlip, MEM_Jump, MEM_zr  input  1  branch controls and zero flag at MEM.
- MEM_MemRead, MEM_MemWrite  input  1  data-memory access in MEM.
- MEM_branch_addr, MEM_jump_addr  input  ADDR_W  redirect targets.
- mem_ready  input  1  data memory completes the access this cycle.
- mem_req  output  1  data-memory request strobe.
- pc_write  output  1  PC register enable.
- pc_sel  output  2  PC source: 0 = sequential, 1 = branch, 2 = jump.
- pc_target  output  ADDR_W  registered redirect target.
- IFID_write, IDEX_write, EXMEM_write  output  1  pipeline register enables.
- IFID_flush, IDEX_flush, EXMEM_flush  output  1  synchronous clear to a bubble.
- stall_cnt, flush_cnt  output  16  performance counters (see Optional Feature).

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT, REDIRECT. Reset → RUN.
- Registered state: 3-bit bubble counter, pc_sel_q, pc_target_q.
- While rst=1:
  - pc_write=0, all *_write=0, all *_flush=1, mem_req=0.
  - pc_sel=0, pc_target=0, counters cleared.
  - Reset mid-stall/mid-wait abandons the operation.
- Derived signals (combinational):
  - taken = MEM_Jump | (MEM_Branch & (MEM_zr ^ MEM_BranchFlip)).
  - mem_busy = (MEM_MemRead | MEM_MemWrite) & ~mem_ready.
  - lu = EX_MemRead & (EX_reg_write_addr != 0) & ((ID_uses_rs1 & ID_rs1 == EX_reg_write_addr) | (ID_uses_rs2 & ID_rs2 == EX_reg_write_addr)).
- mem_req = MEM_MemRead | MEM_MemWrite in every non-reset state.
- Default outputs (RUN, no event): all *_write=1, flushes=0, pc_write=1, pc_sel=0.
- Priority each cycle: mem_busy > taken > lu.
- mem_busy (any state except REDIRECT):
  - All *_write=0, pc_write=0, flushes=0.
  - Next state MEM_WAIT; stay until mem_ready=1.
  - In the mem_ready cycle, outputs are as RUN, and the next state is RUN.
  - taken and lu are evaluated normally in that same cycle.
- taken (RUN, LU_STALL or completing MEM_WAIT):
  - Latch pc_sel_q (2 if MEM_Jump, else 1) and pc_target_q (MEM_jump_addr or MEM_branch_addr).
  - Next state REDIRECT. Pipeline advances normally this cycle.
  - Any in-progress load-use stall is aborted and the counter is cleared.
- REDIRECT (exactly 1 cycle):
  - pc_write=1, pc_sel=pc_sel_q, pc_target=pc_target_q.
  - IFID_flush=IDEX_flush=EXMEM_flush=1, all *_write=1.
  - Next state RUN. Inputs are ignored in this cycle, including mem_busy: a flushed access never stalls.
- lu in RUN (same cycle, combinational):
  - pc_write=0, IFID_write=0, IDEX_flush=1, IDEX_write=1, EXMEM_write=1.
  - If LU_STALL_CYCLES > 1: counter ← LU_STALL_CYCLES−1, next state LU_STALL. Otherwise stay in RUN.
- LU_STALL:
  - Same outputs as an lu cycle.
  - Counter decrements each cycle; at 1 → RUN.
  - The counter does not decrement in a cycle where mem_busy=1.
- pc_target reads 0 outside REDIRECT.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on every non-reset cycle with pc_write=0.
  - flush_cnt increments on every REDIRECT cycle.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: both ports are tied to 16'h0000 and no counter flops are generated.

Test Plan:
- Reset: hold rst=1 for 2 cycles → all flushes=1, pc_write=0. First cycle after release → RUN defaults, pc_sel=0.
- Load-use: EX_MemRead=1, EX_reg_write_addr=5, ID_rs1=5, ID_uses_rs1=1, LU_STALL_CYCLES=1 → exactly 1 cycle with pc_write=0, IFID_write=0, IDEX_flush=1, then RUN. Repeat with addr 0 → no stall.
- Branch: MEM_Branch=1, MEM_zr=1, MEM_BranchFlip=0, MEM_branch_addr=32'h40 → next cycle pc_sel=1, pc_target=32'h40, all three flushes=1 for one cycle. With BranchFlip=1 → no redirect.
- Memory wait: MEM_MemRead=1, mem_ready low for 3 cycles → 3 cycles with all writes=0, mem_req=1. Cycle with mem_ready=1 → writes=1.
- Priority: jump (MEM_jump_addr=32'h80) in MEM during LU_STALL with LU_STALL_CYCLES=3 → stall aborted, REDIRECT next cycle with pc_sel=2, pc_target=32'h80.
- HAZARD_PERF_EN: run the above sequence → stall_cnt equals the number of pc_write=0 cycles, flush_cnt=2. Preload stall_cnt near 16'hFFFF → it saturates at 16'hFFFF.
